// File: rtl/sw_target_feeder_if.sv
// sw_target_feeder_if: record input, per-channel base stream and ID FIFO port bundle.
// master drives records/stall/pops; slave is the feeder.
interface sw_target_feeder_if #(
    parameter int ID_WIDTH = 48,
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int IN_WIDTH = 316
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CH_W-1:0]              in_ch;
    logic [IN_WIDTH-1:0]          in_data;
    logic [NUM_CH-1:0]            stall;
    logic [NUM_CH-1:0]            base_valid;
    logic [2*NUM_CH-1:0]          base_out;
    logic [NUM_CH-1:0]            base_last;
    logic [NUM_CH*ID_WIDTH-1:0]   id_out;
    logic [NUM_CH-1:0]            id_valid;
    logic [NUM_CH-1:0]            id_re;
    logic                         err_len;

    modport master (
        output in_valid, in_ch, in_data, stall, id_re,
        input  in_ready, base_valid, base_out, base_last, id_out, id_valid, err_len
    );
    modport slave (
        input  in_valid, in_ch, in_data, stall, id_re,
        output in_ready, base_valid, base_out, base_last, id_out, id_valid, err_len
    );
endinterface

// File: rtl/sw_target_feeder.sv
// sw_target_feeder: steers target records to NUM_CH channels, streams one base per cycle each.
// SW_FEEDER_LEN_CHECK_EN: drop records whose LENGTH is 0 or exceeds TARGET_LENGTH, pulse err_len.
module sw_target_feeder #(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int NUM_CH        = 2,
    parameter int CH_W          = 1,
    parameter int ID_DEPTH      = 4,
    parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    sw_target_feeder_if.slave bus
);
    localparam int PW = ID_DEPTH > 1 ? $clog2(ID_DEPTH) : 1;
    localparam int FW = $clog2(ID_DEPTH + 1);
    typedef enum logic {IDLE, FEED} state_t;

    logic [ID_WIDTH-1:0]        in_id;
    logic [LEN_WIDTH-1:0]       in_len;
    logic [2*TARGET_LENGTH-1:0] in_tgt;
    logic                       bad, take, err_q;
    logic [NUM_CH-1:0]          rdy, ld;
    logic [2**CH_W-1:0]         rdy_x;

    assign in_id  = bus.in_data[IN_WIDTH-1 -: ID_WIDTH];
    assign in_len = bus.in_data[2*TARGET_LENGTH +: LEN_WIDTH];
    assign in_tgt = bus.in_data[2*TARGET_LENGTH-1:0];
    // zero-extended so an out-of-range channel select reads as not ready
    assign rdy_x        = (2**CH_W)'(rdy);
    assign bus.in_ready = rst & rdy_x[bus.in_ch];
    assign take         = bus.in_valid & bus.in_ready;
`ifdef SW_FEEDER_LEN_CHECK_EN
    assign bad = (in_len == '0) | (in_len > LEN_WIDTH'(TARGET_LENGTH));
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk) err_q <= rst & take & bad;
    assign bus.err_len = rst & err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                     state_q;
        logic [2*TARGET_LENGTH-1:0] shift_q;
        logic [LEN_WIDTH-1:0]       len_q, cnt_q;
        logic [ID_WIDTH-1:0]        mem_q [ID_DEPTH];
        logic [PW-1:0]              wp_q, rp_q;
        logic [FW-1:0]              fill_q;
        logic                       feed, last, pop, idv;

        assign ld[c]  = take & ~bad & (bus.in_ch == CH_W'(c));
        assign feed   = state_q == FEED;
        assign last   = feed & (cnt_q == len_q - LEN_WIDTH'(1));
        assign idv    = fill_q != '0;
        assign pop    = bus.id_re[c] & idv;
        // a finishing channel can take its next record on the last-base edge
        assign rdy[c] = (fill_q != FW'(ID_DEPTH)) & (~feed | (last & ~bus.stall[c]));

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= IDLE;
                shift_q <= '0;
                len_q   <= '0;
                cnt_q   <= '0;
            end else if (ld[c]) begin
                state_q <= FEED;
                shift_q <= in_tgt;
                len_q   <= in_len;
                cnt_q   <= '0;
            end else if (feed && !bus.stall[c]) begin
                shift_q <= shift_q >> 2;
                cnt_q   <= cnt_q + LEN_WIDTH'(1);
                if (last) state_q <= IDLE;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wp_q   <= '0;
                rp_q   <= '0;
                fill_q <= '0;
            end else begin
                if (ld[c]) wp_q <= (wp_q == PW'(ID_DEPTH-1)) ? '0 : wp_q + PW'(1);
                if (pop) rp_q <= (rp_q == PW'(ID_DEPTH-1)) ? '0 : rp_q + PW'(1);
                fill_q <= fill_q + FW'(ld[c]) - FW'(pop);
            end
        end

        always_ff @(posedge clk) if (ld[c]) mem_q[wp_q] <= in_id;

        assign bus.base_valid[c]                  = rst & feed;
        assign bus.base_out[2*c +: 2]             = (rst & feed) ? shift_q[1:0] : 2'b00;
        assign bus.base_last[c]                   = rst & last;
        assign bus.id_valid[c]                    = rst & idv;
        assign bus.id_out[c*ID_WIDTH +: ID_WIDTH] = (rst & idv) ? mem_q[rp_q] : '0;
    end
endmodule

// File: tb/tb_sw_target_feeder.sv
// tb_sw_target_feeder: directed vectors for sw_target_feeder, checked with immediate assertions.
module tb_sw_target_feeder;
    localparam int TL = 128, LW = 12, IW = 48, NC = 2, CW = 1, DP = 4;
    localparam int DW = IW + LW + 2*TL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int e1[4] = '{1, 2, 3, 0};
    int e2[6] = '{1, 2, 2, 2, 3, 0};
    int e3[5] = '{3, 1, 2, 2, 1};
    int l3[5] = '{0, 0, 1, 0, 1};
    int r3[3] = '{0, 0, 1};

    always #5 clk = ~clk;

    sw_target_feeder_if #(.ID_WIDTH(IW), .NUM_CH(NC), .CH_W(CW), .IN_WIDTH(DW)) bus ();
    sw_target_feeder #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW), .NUM_CH(NC),
                       .CH_W(CW), .ID_DEPTH(DP), .IN_WIDTH(DW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] mk(input logic [IW-1:0] id, input logic [LW-1:0] len,
                                         input logic [2*TL-1:0] t);
        return {id, len, t};
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;
        bus.stall    = '0;
        bus.id_re    = '0;
        tick();
        tick();
        smp();
        chk("rst_valid", 128'(bus.base_valid), 128'(0));
        chk("rst_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_idv", 128'(bus.id_valid), 128'(0));
        chk("rst_idout", 128'(bus.id_out), 128'(0));
        chk("rst_base", 128'(bus.base_out), 128'(0));
        chk("rst_last", 128'(bus.base_last), 128'(0));
        chk("rst_err", 128'(bus.err_len), 128'(0));

        // basic stream on ch0
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ch    = 1'b0;
        bus.in_data  = mk(48'hA5, 12'd4, 256'h39);
        smp();
        chk("t1_ready", 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t1_valid", 128'(bus.base_valid[0]), 128'(1));
            chk("t1_base", 128'(bus.base_out[1:0]), 128'(e1[k]));
            chk("t1_last", 128'(bus.base_last[0]), 128'(k == 3));
            if (k == 0) begin
                chk("t1_idv", 128'(bus.id_valid[0]), 128'(1));
                chk("t1_id", 128'(bus.id_out[IW-1:0]), 128'(48'hA5));
                chk("t1_err", 128'(bus.err_len), 128'(0));
            end
            tick();
        end
        smp();
        chk("t1_done", 128'(bus.base_valid[0]), 128'(0));
        tick();
        bus.id_re = 2'b01;
        tick();
        bus.id_re = 2'b00;
        smp();
        chk("t1_popped", 128'(bus.id_valid[0]), 128'(0));

        // stall holds base 2 for three cycles
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = mk(48'hA5, 12'd4, 256'h39);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.stall = {1'b0, k == 1 || k == 2};
            smp();
            chk("t2_valid", 128'(bus.base_valid[0]), 128'(1));
            chk("t2_base", 128'(bus.base_out[1:0]), 128'(e2[k]));
            chk("t2_last", 128'(bus.base_last[0]), 128'(k == 5));
            tick();
        end
        bus.stall = '0;
        smp();
        chk("t2_done", 128'(bus.base_valid[0]), 128'(0));
        chk("t2_id", 128'(bus.id_out[IW-1:0]), 128'(48'hA5));
        tick();
        bus.id_re = 2'b01;
        tick();
        bus.id_re = 2'b00;

        // back-to-back reload on the last-base edge
        bus.in_valid = 1'b1;
        bus.in_data  = mk(48'h11, 12'd3, 256'h27);
        tick();
        bus.in_data = mk(48'h22, 12'd2, 256'h6);
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t3_valid", 128'(bus.base_valid[0]), 128'(1));
            chk("t3_base", 128'(bus.base_out[1:0]), 128'(e3[k]));
            chk("t3_last", 128'(bus.base_last[0]), 128'(l3[k]));
            if (k < 3) chk("t3_ready", 128'(bus.in_ready), 128'(r3[k]));
            tick();
            if (k == 2) bus.in_valid = 1'b0;
        end
        smp();
        chk("t3_done", 128'(bus.base_valid[0]), 128'(0));
        chk("t3_id0", 128'(bus.id_out[IW-1:0]), 128'(48'h11));
        tick();
        bus.id_re = 2'b01;
        tick();
        bus.id_re = 2'b00;
        smp();
        chk("t3_id1", 128'(bus.id_out[IW-1:0]), 128'(48'h22));
        tick();
        bus.id_re = 2'b01;
        tick();
        bus.id_re = 2'b00;
        smp();
        chk("t3_empty", 128'(bus.id_valid[0]), 128'(0));

        // fill ch1 ID FIFO with L=1 records
        tick();
        bus.in_ch    = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = mk(48'(48'h100 + i), 12'd1, 256'((i + 1) % 4));
            smp();
            chk("t4_ready", 128'(bus.in_ready), 128'(i < 4));
            if (i == 1) begin
                chk("t4_base", 128'(bus.base_out[3:2]), 128'(1));
                chk("t4_last", 128'(bus.base_last[1]), 128'(1));
            end
            if (i < 4) tick();
        end
        chk("t4_head", 128'(bus.id_out[IW +: IW]), 128'(48'h100));
        tick();
        bus.id_re = 2'b10;
        smp();
        chk("t4_full", 128'(bus.in_ready), 128'(0));
        tick();
        bus.id_re = 2'b00;
        smp();
        chk("t4_ready5", 128'(bus.in_ready), 128'(1));
        chk("t4_head1", 128'(bus.id_out[IW +: IW]), 128'(48'h101));
        tick();
        bus.in_valid = 1'b0;
        smp();
        chk("t4_valid5", 128'(bus.base_valid[1]), 128'(1));
        chk("t4_base5", 128'(bus.base_out[3:2]), 128'(1));
        bus.id_re = 2'b10;
        for (int j = 0; j < 4; j++) begin
            chk("t4_pop", 128'(bus.id_out[IW +: IW]), 128'(48'h101 + j));
            tick();
            smp();
        end
        chk("t4_empty", 128'(bus.id_valid[1]), 128'(0));
        tick();
        smp();
        chk("t4_empty_re", 128'(bus.id_valid[1]), 128'(0));
        bus.id_re = 2'b00;

`ifdef SW_FEEDER_LEN_CHECK_EN
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.in_ch    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = mk(48'h77, (i == 0) ? 12'd0 : 12'd129, 256'h1B);
            smp();
            chk("t5_ready", 128'(bus.in_ready), 128'(1));
            tick();
            bus.in_valid = 1'b0;
            smp();
            chk("t5_err", 128'(bus.err_len), 128'(1));
            chk("t5_valid", 128'(bus.base_valid[0]), 128'(0));
            chk("t5_idv", 128'(bus.id_valid[0]), 128'(0));
            tick();
            smp();
            chk("t5_err_off", 128'(bus.err_len), 128'(0));
        end
`endif

        // reset while both channels stream
        tick();
        bus.in_ch    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(48'h33, 12'd4, 256'h39);
        tick();
        bus.in_ch   = 1'b1;
        bus.in_data = mk(48'h44, 12'd4, 256'h39);
        tick();
        bus.in_valid = 1'b0;
        bus.in_ch    = 1'b0;
        smp();
        chk("t6_both", 128'(bus.base_valid), 128'(2'b11));
        tick();
        rst = 1'b0;
        tick();
        smp();
        chk("t6_valid", 128'(bus.base_valid), 128'(0));
        chk("t6_base", 128'(bus.base_out), 128'(0));
        chk("t6_last", 128'(bus.base_last), 128'(0));
        chk("t6_idv", 128'(bus.id_valid), 128'(0));
        chk("t6_idout", 128'(bus.id_out), 128'(0));
        chk("t6_ready", 128'(bus.in_ready), 128'(0));
        chk("t6_err", 128'(bus.err_len), 128'(0));
        tick();
        rst = 1'b1;
        bus.in_ch    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(48'h55, 12'd2, 256'hB);
        tick();
        bus.in_valid = 1'b0;
        smp();
        chk("t6_b0", 128'(bus.base_out[3:2]), 128'(3));
        chk("t6_id", 128'(bus.id_out[IW +: IW]), 128'(48'h55));
        chk("t6_idv2", 128'(bus.id_valid), 128'(2'b10));
        tick();
        smp();
        chk("t6_b1", 128'(bus.base_out[3:2]), 128'(2));
        chk("t6_l1", 128'(bus.base_last[1]), 128'(1));
        tick();
        smp();
        chk("t6_done", 128'(bus.base_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
